// File: rtl/dcache_line_refill_pkg.sv
// Shared types and sizing constants for the dcache line fill / writeback engine.
package dcache_line_refill_pkg;
    localparam int LINE_WORDS_DEF = 8;
    localparam int LINE_W_DEF     = 3;
    localparam int IDX_W_DEF      = 8;
    localparam int RAM_AW         = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_EVICT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/dcache_skid_fifo2.sv
// Two-entry 32-bit FIFO that buffers RAM read data during a writeback burst.
module dcache_skid_fifo2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic [1:0]  count
);
    logic [31:0] ent0, ent1;
    logic        wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0   <= '0;
            ent1   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                if (wr_ptr) ent1 <= push_data;
                else        ent0 <= push_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = rd_ptr ? ent1 : ent0;
endmodule

// File: rtl/dcache_line_refill.sv
// Owns data RAM port 1: refills a line from memory on a miss, streams a dirty
// line back to memory on an eviction.
module dcache_line_refill
    import dcache_line_refill_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int LINE_W     = LINE_W_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fill_req_i,
    input  logic              evict_req_i,
    input  logic [IDX_W-1:0]  line_idx_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              mem_rd_valid_i,
    input  logic [31:0]       mem_rd_data_i,
    output logic              mem_rd_ready_o,
    output logic              mem_wr_valid_o,
    output logic [31:0]       mem_wr_data_o,
    output logic              mem_wr_last_o,
    input  logic              mem_wr_ready_i,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_data_o,
    output logic [3:0]        ram_wr_o,
    input  logic [31:0]       ram_data_i
);
    localparam logic [LINE_W-1:0] LAST_WORD = LINE_W'(LINE_WORDS - 1);

    state_e            state, state_nx;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] word_cnt, out_cnt;
    logic [LINE_W:0]   rd_cnt;
    logic              inflight;
    logic [1:0]        fifo_cnt;
    logic [31:0]       fifo_head;
    logic              start, fill_acc, wr_hs, rd_issue;

    assign start    = (state == ST_IDLE) && (fill_req_i || evict_req_i);
    assign fill_acc = (state == ST_FILL) && mem_rd_valid_i;
    assign wr_hs    = (state == ST_EVICT) && (fifo_cnt != 2'd0) && mem_wr_ready_i;
    // Occupancy counts the beat leaving this cycle so a held-high ready sees no bubbles.
    assign rd_issue = (state == ST_EVICT) && !rd_cnt[LINE_W] &&
                      ((fifo_cnt - 2'(wr_hs) + 2'(inflight)) < 2'd2);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (evict_req_i)     state_nx = ST_EVICT;
                else if (fill_req_i) state_nx = ST_FILL;
            end
            ST_FILL:  if (fill_acc && word_cnt == LAST_WORD) state_nx = ST_DONE;
            ST_EVICT: if (wr_hs && out_cnt == LAST_WORD)     state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o         = (state != ST_IDLE);
        done_o         = 1'b0;
        mem_rd_ready_o = 1'b0;
        mem_wr_valid_o = 1'b0;
        mem_wr_last_o  = 1'b0;
        ram_addr_o     = '0;
        ram_data_o     = '0;
        ram_wr_o       = '0;
        case (state)
            ST_FILL: begin
                mem_rd_ready_o = 1'b1;
                if (mem_rd_valid_i) begin
                    ram_addr_o = {idx_q, word_cnt};
                    ram_data_o = mem_rd_data_i;
                    ram_wr_o   = 4'hF;
                end
            end
            ST_EVICT: begin
                mem_wr_valid_o = (fifo_cnt != 2'd0);
                mem_wr_last_o  = mem_wr_valid_o && (out_cnt == LAST_WORD);
                if (rd_issue) ram_addr_o = {idx_q, rd_cnt[LINE_W-1:0]};
            end
            ST_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    assign mem_wr_data_o = fifo_head;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_q    <= '0;
            word_cnt <= '0;
            rd_cnt   <= '0;
            out_cnt  <= '0;
            inflight <= 1'b0;
        end else if (start) begin
            idx_q    <= line_idx_i;
            word_cnt <= '0;
            rd_cnt   <= '0;
            out_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (fill_acc) word_cnt <= word_cnt + 1'b1;
            if (rd_issue) rd_cnt   <= rd_cnt + 1'b1;
            if (wr_hs)    out_cnt  <= out_cnt + 1'b1;
            inflight <= rd_issue;
        end
    end

    // RAM read data returns one cycle after issue and lands straight in the FIFO.
    dcache_skid_fifo2 u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (inflight),
        .push_data (ram_data_i),
        .pop       (wr_hs),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );
endmodule

// File: tb/tb_dcache_line_refill.sv
// Directed bench for dcache_line_refill: behavioural RAM, expected-event queues, per-cycle compare.
module tb_dcache_line_refill;
    logic        clk_i = 1'b0;
    logic        rst_i, fill_req_i, evict_req_i;
    logic [7:0]  line_idx_i;
    logic        busy_o, done_o;
    logic        mem_rd_valid_i, mem_rd_ready_o;
    logic [31:0] mem_rd_data_i;
    logic        mem_wr_valid_o, mem_wr_last_o, mem_wr_ready_i;
    logic [31:0] mem_wr_data_o;
    logic [10:0] ram_addr_o;
    logic [31:0] ram_data_o, ram_data_i;
    logic [3:0]  ram_wr_o;

    always #5 clk_i = ~clk_i;

    dcache_line_refill dut (
        .clk_i(clk_i), .rst_i(rst_i), .fill_req_i(fill_req_i), .evict_req_i(evict_req_i),
        .line_idx_i(line_idx_i), .busy_o(busy_o), .done_o(done_o),
        .mem_rd_valid_i(mem_rd_valid_i), .mem_rd_data_i(mem_rd_data_i), .mem_rd_ready_o(mem_rd_ready_o),
        .mem_wr_valid_o(mem_wr_valid_o), .mem_wr_data_o(mem_wr_data_o), .mem_wr_last_o(mem_wr_last_o),
        .mem_wr_ready_i(mem_wr_ready_i), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_wr_o(ram_wr_o), .ram_data_i(ram_data_i)
    );

    // Behavioural RAM: untouched words hold a value derived from their address.
    logic [31:0] ram [2048];
    bit          wv  [2048];

    function automatic logic [31:0] init_val(input logic [10:0] a);
        if (a[10:3] == 8'hFF) return 32'h100 + 32'(a[2:0]);
        return 32'hE000_0000 | 32'(a);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [10:0] a);
        return wv[a] ? ram[a] : init_val(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk_i) begin
        ram_data_i <= mem_rd(ram_addr_o);
        if (ram_wr_o != 4'h0) begin
            ram[ram_addr_o] <= merge(mem_rd(ram_addr_o), ram_data_o, ram_wr_o);
            wv[ram_addr_o]  <= 1'b1;
        end
    end

    typedef struct { logic [10:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [31:0] d; logic last; } beat_t;
    wr_t   exp_wr[$];
    beat_t exp_beat[$];
    int n_chk = 0, n_pass = 0;
    int issued = 0, accepted = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Per-cycle compare of RAM writes and writeback beats against the expected queues.
    initial forever begin
        wr_t w;
        beat_t bt;
        @(negedge clk_i);
        if (rst_i) begin
            if (ram_wr_o != 4'h0) begin
                if (exp_wr.size() == 0) check("ram_wr_unexpected", 32'(ram_wr_o), 32'h0);
                else begin
                    w = exp_wr.pop_front();
                    check("fill_addr", 32'(ram_addr_o), 32'(w.a));
                    check("fill_data", ram_data_o, w.d);
                    check("fill_strb", 32'(ram_wr_o), 32'hF);
                end
            end
            if (mem_wr_valid_o) begin
                if (exp_beat.size() == 0) check("beat_unexpected", 32'(mem_wr_valid_o), 32'h0);
                else begin
                    bt = exp_beat[0];
                    check("beat_data", mem_wr_data_o, bt.d);
                    check("beat_last", 32'(mem_wr_last_o), 32'(bt.last));
                    if (mem_wr_ready_i) begin
                        void'(exp_beat.pop_front());
                        accepted++;
                    end
                end
            end
            if (!busy_o) begin
                issued = 0;
                accepted = 0;
            end else if (ram_wr_o == 4'h0 && ram_addr_o != 11'h0) begin
                issued++;
                check("buffered_plus_inflight_le2", 32'(issued - accepted > 2), 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_fill(input logic [7:0] idx, input logic [31:0] base, input bit gaps);
        int k, cyc;
        for (int i = 0; i < 8; i++) exp_wr.push_back('{a: {idx, 3'(i)}, d: base + 32'(i)});
        fill_req_i = 1'b1;
        line_idx_i = idx;
        tick();
        fill_req_i = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 64) begin
            mem_rd_valid_i = gaps ? (cyc % 3 == 0) : 1'b1;
            mem_rd_data_i  = mem_rd_valid_i ? base + 32'(k) : 32'hDEAD_BEEF;
            if (mem_rd_valid_i) k++;
            tick();
            cyc++;
        end
        mem_rd_valid_i = 1'b0;
        check("fill_accepts", 32'(k), 32'd8);
        @(negedge clk_i);
        check("fill_done_pulse", 32'(done_o), 32'h1);
        check("fill_busy_in_done", 32'(busy_o), 32'h1);
        tick();
        @(negedge clk_i);
        check("fill_done_cleared", 32'(done_o), 32'h0);
        check("fill_busy_dropped", 32'(busy_o), 32'h0);
        check("fill_writes_pending", 32'(exp_wr.size()), 32'h0);
        tick();
    endtask

    // mode 0: ready high, timing pinned; 1: random ready; 2: simultaneous fill + busy request
    task automatic do_evict(input logic [7:0] idx, input int mode);
        int cyc;
        bit seen_done;
        for (int i = 0; i < 8; i++) exp_beat.push_back('{d: mem_rd({idx, 3'(i)}), last: (i == 7)});
        evict_req_i = 1'b1;
        fill_req_i  = (mode == 2);
        line_idx_i  = idx;
        mem_rd_valid_i = (mode == 2);
        tick();
        evict_req_i = 1'b0;
        fill_req_i  = 1'b0;
        cyc = 0;
        seen_done = 0;
        while (cyc < 200 && !seen_done) begin
            mem_wr_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            fill_req_i = (mode == 2 && cyc == 3);
            line_idx_i = (mode == 2 && cyc == 3) ? 8'h20 : idx;
            @(negedge clk_i);
            if (mode == 0 && cyc < 2) check("evict_no_early_valid", 32'(mem_wr_valid_o), 32'h0);
            if (mode == 0 && cyc == 2) begin
                check("evict_first_valid", 32'(mem_wr_valid_o), 32'h1);
                check("evict_first_data", mem_wr_data_o, 32'h100);
            end
            if (mode == 2 && cyc == 1) check("evict_not_fill_ready", 32'(mem_rd_ready_o), 32'h0);
            if (done_o) seen_done = 1;
            else begin
                tick();
                cyc++;
            end
        end
        fill_req_i = 1'b0;
        check("evict_done_seen", 32'(seen_done), 32'h1);
        if (mode == 0) check("evict_done_cycle", 32'(cyc), 32'd10);
        check("evict_beats_pending", 32'(exp_beat.size()), 32'h0);
        mem_wr_ready_i = 1'b0;
        tick();
        @(negedge clk_i);
        check("evict_busy_dropped", 32'(busy_o), 32'h0);
        tick();
    endtask

    initial begin
        rst_i = 1'b0; fill_req_i = 1'b0; evict_req_i = 1'b0; line_idx_i = '0;
        mem_rd_valid_i = 1'b0; mem_rd_data_i = '0; mem_wr_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        check("rst_rd_ready", 32'(mem_rd_ready_o), 32'h0);
        check("rst_wr_valid", 32'(mem_wr_valid_o), 32'h0);
        check("rst_wr_data", mem_wr_data_o, 32'h0);
        check("rst_ram_wr", 32'(ram_wr_o), 32'h0);
        tick();
        rst_i = 1'b1;
        tick();

        do_fill(8'h05, 32'hA0, 1'b0);
        check("ram_028", ram[11'h028], 32'hA0);
        check("ram_02f", ram[11'h02F], 32'hA7);

        do_fill(8'h09, 32'hB0, 1'b1);
        check("ram_04c", ram[11'h04C], 32'hB4);

        do_evict(8'hFF, 0);
        do_evict(8'h40, 1);
        do_evict(8'h10, 2);
        check("dropped_fill_no_write", 32'(wv[11'h080]), 32'h0);
        mem_rd_valid_i = 1'b1;
        tick();
        tick();
        @(negedge clk_i);
        check("no_fill_after_evict", 32'(busy_o), 32'h0);
        mem_rd_valid_i = 1'b0;
        tick();

        // Reset three words into a refill of line 0x33.
        for (int i = 0; i < 3; i++) exp_wr.push_back('{a: {8'h33, 3'(i)}, d: 32'hD0 + 32'(i)});
        fill_req_i = 1'b1;
        line_idx_i = 8'h33;
        tick();
        fill_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_rd_valid_i = 1'b1;
            mem_rd_data_i  = 32'hD0 + 32'(i);
            tick();
        end
        #2 rst_i = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'h0);
        check("midrst_ram_wr", 32'(ram_wr_o), 32'h0);
        check("midrst_rd_ready", 32'(mem_rd_ready_o), 32'h0);
        check("midrst_ram_addr", 32'(ram_addr_o), 32'h0);
        check("partial_word2", ram[11'h19A], 32'hD2);
        check("partial_word3_untouched", 32'(wv[11'h19B]), 32'h0);
        check("midrst_writes_pending", 32'(exp_wr.size()), 32'h0);
        exp_wr.delete();
        tick();
        mem_rd_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        do_fill(8'h33, 32'hC0, 1'b0);
        check("refill_word0", ram[11'h198], 32'hC0);
        check("refill_word7", ram[11'h19F], 32'hC7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
